ring_decoder: RTL
=================

# ring_decoder

Receive-side checker for the one-hot ring code produced by the team's ring counters. Takes the ring pattern plus a sample strobe and converts each one-hot word to a binary step index. It verifies that successive samples follow the ring sequence (one-hot bit shifting toward bit 0, bit 0 wrapping to bit N-1), declares lock after a run of correct steps, and counts completed revolutions. It sits at the end of any ring-counter-sequenced path where the sequence must be monitored or turned into an address.

## Interface
- N, 4: ring width in bits; N ≥ 2.
- LOCK_LEN, 2: consecutive correct successor steps needed to enter LOCKED; ≥ 1.
- REV_W, 8: width of the revolution counter.
- IW (localparam) = $clog2(N).

- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high. Asserting it clears all state and outputs immediately.
- ring_in  input  N  sampled ring word.
- in_valid  input  1  ring_in holds a new sample this cycle. Low means a stall: nothing changes.
- index  output  IW  step number of the last accepted one-hot sample. Bit N-1 maps to 0, bit N-2 to 1, and so on down to bit 0, which maps to N-1.
- index_valid  output  1  pulse: index was updated by the sample one cycle earlier.
- locked  output  1  level: the FSM is in LOCKED.
- step_err  output  1  pulse: a one-hot sample in LOCKED was not the expected successor.
- code_err  output  1  pulse: a valid sample was not one-hot (zero bits set or more than one).
- wrap  output  1  pulse: a revolution completed.
- rev_count  output  REV_W  number of revolutions, modulo 2^REV_W.

## Operation
- Internal state:
  - ref: last accepted one-hot word.
  - ref_ok: ref holds a valid word.
  - good: successor run count, saturating at LOCK_LEN.
  - state: SEARCH or LOCKED.
- Successor of word w: rotate right by 1. So 1000 → 0100 → 0010 → 0001 → 1000 for N=4. Equality with ref (repeat) is not a successor.
- A cycle with in_valid=0 changes nothing. All pulses are 0 in that cycle's output.
- Valid sample, not one-hot:
  - code_err=1.
  - index holds its value; index_valid=0.
  - ref_ok←0, good←0, state←SEARCH.
  - step_err is not asserted.
- Valid sample, one-hot (call it s):
  - index←enc(s), index_valid=1, ref←s, ref_ok←1.
  - SEARCH:
    - If ref_ok and s=succ(ref), good←good+1. When good+1 = LOCK_LEN, state←LOCKED.
    - Otherwise good←0. This includes the first sample after reset or after a code error.
  - LOCKED:
    - If s=succ(ref), stay in LOCKED.
    - Otherwise step_err=1, state←SEARCH, good←0. s becomes the new reference.
  - Revolution: wrap=1 and rev_count←rev_count+1 only when the state before the sample is LOCKED, s=succ(ref), and s=1 at bit N-1 (index 0). rev_count wraps from 2^REV_W−1 to 0 silently.
- Every input is a glitch-free registered signal from the same clock domain. No synchronizer is needed.

## Timing
- Latency: all outputs are registered, and update on the rising edge that samples in_valid=1.
  - A sample presented in cycle t shows on index, index_valid and the pulses in cycle t+1.
  - locked rises in cycle t+1 for the sample that completes LOCK_LEN.
  - locked falls in cycle t+1 for a step_err or code_err sample.
- Pulses last exactly one cycle per offending or qualifying sample. Back-to-back samples can give back-to-back pulses.
- Reset values: index=0, index_valid=0, locked=0, step_err=0, code_err=0, wrap=0, rev_count=0. Internally: state=SEARCH, good=0, ref_ok=0, ref=0.
- Reset mid-operation: outputs clear without waiting for a clock edge. The first valid sample after release is reference-only, with good=0.
- rev_count is not cleared by loss of lock. Only rst clears it.

## Structure
- Shared package ring_pkg holds:
  - typedef ring_state_t {SEARCH, LOCKED};
  - the successor (rotate-right) function;
  - the is-one-hot function.
  These are reused by ring-counter generators.
- One sub-module is natural: ring_onehot_enc. It is a parameterized combinational one-hot-to-index encoder with a `onehot` flag output, and is reused elsewhere.
- FSM, good counter, reference register and revolution counter all live in ring_decoder.

## Test plan
All scenarios use N=4, LOCK_LEN=2, REV_W=8.
1. After reset, feed 1000, 0100, 0010 on consecutive cycles → index 0, 1, 2 with index_valid=1 each cycle. locked=1 from the cycle after 0010. No pulses.
2. While locked at 0010, feed 0001, 1000 → index 3, then 0. wrap=1 on the 1000 output cycle; rev_count goes 0 → 1.
3. While locked with ref=0100, feed 0001 → step_err=1, locked=0, index=3. Then feed 1000, 0100 → locked=1 again after 0100.
4. While locked, feed 0110, then 0000 → code_err=1 on both output cycles, index_valid=0, index unchanged, locked=0. The next one-hot sample is reference-only.
5. While locked, hold in_valid=0 for 5 cycles, then feed the correct successor → outputs unchanged during the gap, locked stays 1, no step_err. Separately, feeding the same word twice → step_err=1.
6. Run 256 locked revolutions → rev_count wraps from 255 to 0 with wrap=1. Asserting rst asynchronously mid-sequence → every output is 0 before the next edge; after release, 0100 then 0010 gives locked=0 until one more correct step.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg -- shared definitions for one-hot ring-code generators and checkers.
//
// Contents:
//   RING_MAX_W      widest ring the helper functions accept
//   ring_state_t    SEARCH / LOCKED tracking state
//   ring_succ()     successor of a ring word (rotate right by one inside n bits)
//   ring_is_onehot  true when exactly one bit is set
//
// The helpers work on RING_MAX_W-bit vectors so that rings of any width up to
// RING_MAX_W can share them. Callers zero-extend their N-bit word, and bits at
// and above n must be zero.
package ring_pkg;

  localparam int unsigned RING_MAX_W = 64;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ring_state_t;

  // The shift moves bit 0 out, and it is then re-inserted at bit n-1.
  // The upper bits stay zero because the input is zero above n.
  function automatic logic [RING_MAX_W-1:0] ring_succ(
    input logic [RING_MAX_W-1:0] w,
    input int unsigned           n
  );
    logic [RING_MAX_W-1:0] r;
    r        = w >> 1;
    r[n - 1] = w[0];
    return r;
  endfunction

  function automatic logic ring_is_onehot(input logic [RING_MAX_W-1:0] w);
    return ($countones(w) == 1);
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc -- combinational one-hot to step-index encoder.
//
// Ring bit N-1 maps to index 0, bit N-2 to index 1, and so on down to bit 0,
// which maps to index N-1. index_o is meaningful only while onehot_o is high.
//
// Ports:
//   ring_i    [N-1:0]   ring word
//   index_o   [IW-1:0]  step index of the set bit
//   onehot_o            exactly one bit of ring_i is set
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  ring_i,
  output logic [IW-1:0] index_o,
  output logic          onehot_o
);

  always_comb begin
    index_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ring_i[i]) begin
        index_o = index_o | IW'(N - 1 - i);
      end
    end
    onehot_o = ring_is_onehot(RING_MAX_W'(ring_i));
  end

endmodule

// File: rtl/ring_decoder.sv
// ring_decoder -- receive-side checker for one-hot ring-counter codes.
//
// Each valid sample is converted to a binary step index. The decoder checks
// that consecutive samples follow the ring order (rotate right, bit 0 wrapping
// to bit N-1), declares lock after LOCK_LEN correct steps in a row, and counts
// completed revolutions while locked.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   ring_in      [N-1:0] sampled ring word
//   in_valid     ring_in carries a new sample (low = stall, nothing changes)
//   index        [IW-1:0] step index of the last accepted one-hot sample
//   index_valid  pulse: index was updated by the previous cycle's sample
//   locked       level: tracking state is LOCKED
//   step_err     pulse: a one-hot sample in LOCKED was not the successor
//   code_err     pulse: a valid sample was not one-hot
//   wrap         pulse: a revolution completed (locked step into index 0)
//   rev_count    [REV_W-1:0] revolutions seen, modulo 2^REV_W
module ring_decoder
  import ring_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned REV_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         ring_in,
  input  logic                 in_valid,
  output logic [$clog2(N)-1:0] index,
  output logic                 index_valid,
  output logic                 locked,
  output logic                 step_err,
  output logic                 code_err,
  output logic                 wrap,
  output logic [REV_W-1:0]     rev_count
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned GW = $clog2(LOCK_LEN + 1);

  ring_state_t      state_q;
  logic [N-1:0]     ref_q;
  logic             ref_ok_q;
  logic [GW-1:0]    good_q;
  logic [IW-1:0]    index_q;
  logic             index_valid_q;
  logic             step_err_q;
  logic             code_err_q;
  logic             wrap_q;
  logic [REV_W-1:0] rev_count_q;

  logic [IW-1:0]    enc_index;
  logic             enc_onehot;
  logic             is_succ;
  logic             run_done;

  ring_onehot_enc #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .ring_i   (ring_in),
    .index_o  (enc_index),
    .onehot_o (enc_onehot)
  );

  // A repeat of ref never matches, because the rotated word differs from ref
  // whenever ref is one-hot and N >= 2.
  assign is_succ  = ref_ok_q &&
                    (RING_MAX_W'(ring_in) == ring_succ(RING_MAX_W'(ref_q), N));
  assign run_done = ((int'(good_q) + 1) == int'(LOCK_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      ref_q         <= '0;
      ref_ok_q      <= 1'b0;
      good_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      step_err_q    <= 1'b0;
      code_err_q    <= 1'b0;
      wrap_q        <= 1'b0;
      rev_count_q   <= '0;
    end else begin
      index_valid_q <= 1'b0;
      step_err_q    <= 1'b0;
      code_err_q    <= 1'b0;
      wrap_q        <= 1'b0;

      if (in_valid) begin
        if (!enc_onehot) begin
          code_err_q <= 1'b1;
          ref_ok_q   <= 1'b0;
          good_q     <= '0;
          state_q    <= SEARCH;
        end else begin
          index_q       <= enc_index;
          index_valid_q <= 1'b1;
          ref_q         <= ring_in;
          ref_ok_q      <= 1'b1;

          unique case (state_q)
            SEARCH: begin
              if (is_succ) begin
                good_q <= good_q + 1'b1;
                if (run_done) begin
                  state_q <= LOCKED;
                end
              end else begin
                good_q <= '0;
              end
            end
            LOCKED: begin
              if (is_succ) begin
                // Stepping into bit N-1 (index 0) closes one revolution.
                if (ring_in[N-1]) begin
                  wrap_q      <= 1'b1;
                  rev_count_q <= rev_count_q + 1'b1;
                end
              end else begin
                step_err_q <= 1'b1;
                state_q    <= SEARCH;
                good_q     <= '0;
              end
            end
            default: state_q <= SEARCH;
          endcase
        end
      end
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign locked      = (state_q == LOCKED);
  assign step_err    = step_err_q;
  assign code_err    = code_err_q;
  assign wrap        = wrap_q;
  assign rev_count   = rev_count_q;

endmodule
